// File: rtl/rs_pkg.sv
// Shared opcodes, tag sizing and entry type for the Tomasulo reservation station.
package rs_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_SD  = 3'b011;

  localparam int NO_TAG   = 0;
  localparam int NUM_REGS = 8;

  // Tags run 1..entries with 0 reserved for "value ready".
  function automatic int TAG_W(input int entries);
    return $clog2(entries + 1);
  endfunction

  typedef struct packed {
    logic       busy;
    logic       dispatched;
    logic [2:0] op;
    logic [3:0] imm;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority picker over a request vector.
module rs_select
  import rs_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest requesting index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: renames sources against the register status table,
// holds instructions until operands arrive on the CDB and offers ready ones to the FU.
module reservation_station
  import rs_pkg::*;
#(
  parameter  int ENTRIES = 3,
  parameter  int DATA_W  = 16,
  localparam int TB      = TAG_W(ENTRIES),
  localparam int IW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [2:0]        opcode,
  input  logic [2:0]        RX,
  input  logic [2:0]        RY,
  input  logic [2:0]        RZ,
  input  logic [3:0]        immediate,
  output logic              stall,
  output logic              fu_valid,
  input  logic              fu_ready,
  output logic [2:0]        fu_op,
  output logic [DATA_W-1:0] fu_vj,
  output logic [DATA_W-1:0] fu_vk,
  output logic [3:0]        fu_imm,
  output logic [TB-1:0]     fu_tag,
  input  logic              cdb_valid,
  input  logic [TB-1:0]     cdb_tag,
  input  logic [DATA_W-1:0] cdb_data
);

  rs_entry_t         ent_q [ENTRIES];
  rs_entry_t         ent_d [ENTRIES];
  logic [DATA_W-1:0] vj_q  [ENTRIES];
  logic [DATA_W-1:0] vj_d  [ENTRIES];
  logic [DATA_W-1:0] vk_q  [ENTRIES];
  logic [DATA_W-1:0] vk_d  [ENTRIES];
  logic [TB-1:0]     qj_q  [ENTRIES];
  logic [TB-1:0]     qj_d  [ENTRIES];
  logic [TB-1:0]     qk_q  [ENTRIES];
  logic [TB-1:0]     qk_d  [ENTRIES];
  logic [DATA_W-1:0] reg_q [NUM_REGS];
  logic [DATA_W-1:0] reg_d [NUM_REGS];
  logic [TB-1:0]     qi_q  [NUM_REGS];
  logic [TB-1:0]     qi_d  [NUM_REGS];

  logic [ENTRIES-1:0] free_vec, ready_vec;
  logic               alloc_found, disp_found;
  logic [IW-1:0]      alloc_idx, disp_idx;
  logic [DATA_W-1:0]  j_val, k_val;
  logic [TB-1:0]      j_tag, k_tag, new_tag;
  logic               cdb_live;

  rs_select #(.N(ENTRIES), .IDX_W(IW)) u_alloc_sel (
    .req   (free_vec),
    .found (alloc_found),
    .idx   (alloc_idx)
  );

  rs_select #(.N(ENTRIES), .IDX_W(IW)) u_disp_sel (
    .req   (ready_vec),
    .found (disp_found),
    .idx   (disp_idx)
  );

  // Source read: a pending tag that is broadcasting this very cycle is bypassed.
  function automatic logic [DATA_W+TB-1:0] read_src(input logic [2:0] r);
    if (qi_q[r] == TB'(NO_TAG))
      return {reg_q[r], TB'(NO_TAG)};
    else if (cdb_live && (cdb_tag == qi_q[r]))
      return {cdb_data, TB'(NO_TAG)};
    else
      return {{DATA_W{1'b0}}, qi_q[r]};
  endfunction

  always_comb begin
    cdb_live = cdb_valid && (cdb_tag != TB'(NO_TAG));
    for (int i = 0; i < ENTRIES; i++) begin
      free_vec[i]  = !ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && !ent_q[i].dispatched &&
                     (qj_q[i] == TB'(NO_TAG)) && (qk_q[i] == TB'(NO_TAG));
    end
  end

  always_comb begin
    stall    = !alloc_found;
    fu_valid = disp_found;
    fu_op    = '0;
    fu_vj    = '0;
    fu_vk    = '0;
    fu_imm   = '0;
    fu_tag   = '0;
    if (disp_found) begin
      fu_op  = ent_q[disp_idx].op;
      fu_vj  = vj_q[disp_idx];
      fu_vk  = vk_q[disp_idx];
      fu_imm = ent_q[disp_idx].imm;
      fu_tag = TB'(disp_idx) + TB'(1);
    end
  end

  // LD has no second source; SD stores RX, ADD/SUB read RZ.
  always_comb begin
    {j_val, j_tag} = read_src(RY);
    k_val = '0;
    k_tag = '0;
    if (opcode == OP_SD)
      {k_val, k_tag} = read_src(RX);
    else if (opcode != OP_LD)
      {k_val, k_tag} = read_src(RZ);
    new_tag = TB'(alloc_idx) + TB'(1);
  end

  // Order matters: dispatch, then CDB wake-up/free, then issue, so the rename wins.
  always_comb begin
    ent_d = ent_q;
    vj_d  = vj_q;
    vk_d  = vk_q;
    qj_d  = qj_q;
    qk_d  = qk_q;
    reg_d = reg_q;
    qi_d  = qi_q;

    if (disp_found && fu_ready)
      ent_d[disp_idx].dispatched = 1'b1;

    if (cdb_live) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (qj_q[i] == cdb_tag) begin
          vj_d[i] = cdb_data;
          qj_d[i] = TB'(NO_TAG);
        end
        if (qk_q[i] == cdb_tag) begin
          vk_d[i] = cdb_data;
          qk_d[i] = TB'(NO_TAG);
        end
        if (ent_q[i].busy && (cdb_tag == TB'(i + 1))) begin
          ent_d[i].busy       = 1'b0;
          ent_d[i].dispatched = 1'b0;
        end
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        if (qi_q[r] == cdb_tag) begin
          reg_d[r] = cdb_data;
          qi_d[r]  = TB'(NO_TAG);
        end
      end
    end

    if (issue_valid && alloc_found && !opcode[2]) begin
      ent_d[alloc_idx].busy       = 1'b1;
      ent_d[alloc_idx].dispatched = 1'b0;
      ent_d[alloc_idx].op         = opcode;
      ent_d[alloc_idx].imm        = immediate;
      vj_d[alloc_idx]             = j_val;
      qj_d[alloc_idx]             = j_tag;
      vk_d[alloc_idx]             = k_val;
      qk_d[alloc_idx]             = k_tag;
      if (opcode != OP_SD)
        qi_d[RX] = new_tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        reg_q[r] <= DATA_W'(r);
        qi_q[r]  <= '0;
      end
    end else begin
      ent_q <= ent_d;
      vj_q  <= vj_d;
      vk_q  <= vk_d;
      qj_q  <= qj_d;
      qk_q  <= qk_d;
      reg_q <= reg_d;
      qi_q  <= qi_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: rename, CDB wake-up/bypass, stall and async reset.
module tb_reservation_station;
  import rs_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid;
  logic [2:0]  opcode, RX, RY, RZ;
  logic [3:0]  immediate;
  logic        stall, fu_valid, fu_ready;
  logic [2:0]  fu_op;
  logic [15:0] fu_vj, fu_vk;
  logic [3:0]  fu_imm;
  logic [1:0]  fu_tag;
  logic        cdb_valid;
  logic [1:0]  cdb_tag;
  logic [15:0] cdb_data;

  int checks = 0;
  int errors = 0;

  reservation_station #(.ENTRIES(3), .DATA_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .opcode      (opcode),
    .RX          (RX),
    .RY          (RY),
    .RZ          (RZ),
    .immediate   (immediate),
    .stall       (stall),
    .fu_valid    (fu_valid),
    .fu_ready    (fu_ready),
    .fu_op       (fu_op),
    .fu_vj       (fu_vj),
    .fu_vk       (fu_vk),
    .fu_imm      (fu_imm),
    .fu_tag      (fu_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                               input logic [2:0] rz, input logic [3:0] imm);
    issue_valid = 1'b1;
    opcode      = op;
    RX          = rx;
    RY          = ry;
    RZ          = rz;
    immediate   = imm;
  endtask

  task automatic driveCdb(input logic [1:0] tag, input logic [15:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
    end
  endtask

  task automatic checkOffer(input string name, input logic [1:0] tag, input logic [2:0] op,
                            input logic [15:0] vj, input logic [15:0] vk);
    checkOutput({name, ".valid"}, 32'(fu_valid), 32'd1);
    checkOutput({name, ".tag"}, 32'(fu_tag), 32'(tag));
    checkOutput({name, ".op"}, 32'(fu_op), 32'(op));
    checkOutput({name, ".vj"}, 32'(fu_vj), 32'(vj));
    checkOutput({name, ".vk"}, 32'(fu_vk), 32'(vk));
  endtask

  task automatic restart();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    fu_ready  = 1'b1;
    opcode    = '0;
    RX        = '0;
    RY        = '0;
    RZ        = '0;
    immediate = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
    #2 reset = 1'b0;
    tick();
    checkOutput("rst.stall", 32'(stall), 32'd0);
    checkOutput("rst.fu_valid", 32'(fu_valid), 32'd0);
    checkOutput("rst.fu_op", 32'(fu_op), 32'd0);
    checkOutput("rst.fu_vj", 32'(fu_vj), 32'd0);
    checkOutput("rst.fu_vk", 32'(fu_vk), 32'd0);
    checkOutput("rst.fu_imm", 32'(fu_imm), 32'd0);
    checkOutput("rst.fu_tag", 32'(fu_tag), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    $display("[TB] basic issue, dispatch and writeback");
    applyStimulus(OP_ADD, 3'd0, 3'd1, 3'd2, 4'd0);
    tick(); idle();
    checkOffer("t1.add", 2'd1, OP_ADD, 16'd1, 16'd2);
    checkOutput("t1.stall", 32'(stall), 32'd0);
    tick();
    checkOutput("t1.dispatched", 32'(fu_valid), 32'd0);
    driveCdb(2'd1, 16'd3);
    tick(); idle();
    applyStimulus(OP_ADD, 3'd3, 3'd0, 3'd0, 4'd0);
    tick(); idle();
    checkOffer("t1.readR0", 2'd1, OP_ADD, 16'd3, 16'd3);
    tick();
    driveCdb(2'd1, 16'd6);
    tick(); idle();

    $display("[TB] dependency wake-up");
    fu_ready = 1'b0;
    applyStimulus(OP_ADD, 3'd0, 3'd1, 3'd2, 4'd0);
    tick();
    applyStimulus(OP_SUB, 3'd1, 3'd0, 3'd1, 4'd0);
    tick(); idle();
    checkOffer("t2.waiting", 2'd1, OP_ADD, 16'd1, 16'd2);
    driveCdb(2'd1, 16'd3);
    tick(); idle();
    checkOffer("t2.woken", 2'd2, OP_SUB, 16'd3, 16'd1);
    applyStimulus(OP_ADD, 3'd4, 3'd1, 3'd1, 4'd0);
    tick(); idle();
    checkOutput("t2.qi1pending", 32'(fu_tag), 32'd2);
    driveCdb(2'd2, 16'd9);
    tick(); idle();
    checkOffer("t2.r1written", 2'd1, OP_ADD, 16'd9, 16'd9);
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    checkOutput("t2.none_ready", 32'(fu_valid), 32'd0);
    driveCdb(2'd1, 16'd18);
    tick(); idle();

    $display("[TB] stall when full");
    applyStimulus(OP_ADD, 3'd5, 3'd0, 3'd0, 4'd0);
    tick();
    checkOutput("t3.stall1", 32'(stall), 32'd0);
    applyStimulus(OP_ADD, 3'd6, 3'd0, 3'd0, 4'd0);
    tick();
    checkOutput("t3.stall2", 32'(stall), 32'd0);
    applyStimulus(OP_ADD, 3'd7, 3'd0, 3'd0, 4'd0);
    tick();
    checkOutput("t3.stall3", 32'(stall), 32'd1);
    applyStimulus(OP_ADD, 3'd2, 3'd1, 3'd1, 4'd0);
    tick();
    checkOutput("t3.held.stall", 32'(stall), 32'd1);
    checkOffer("t3.held.offer", 2'd1, OP_ADD, 16'd3, 16'd3);
    driveCdb(2'd1, 16'd10);
    tick();
    cdb_valid = 1'b0;
    checkOutput("t3.freed.stall", 32'(stall), 32'd0);
    checkOutput("t3.freed.tag", 32'(fu_tag), 32'd2);
    tick(); idle();
    checkOutput("t3.fourth.stall", 32'(stall), 32'd1);
    checkOffer("t3.fourth", 2'd1, OP_ADD, 16'd9, 16'd9);
    restart();

    $display("[TB] issue-time CDB bypass");
    fu_ready = 1'b1;
    applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd1, 4'd0);
    tick();
    applyStimulus(OP_ADD, 3'd0, 3'd1, 3'd1, 4'd0);
    tick();
    fu_ready = 1'b0;
    checkOutput("t4.pre.tag", 32'(fu_tag), 32'd2);
    applyStimulus(OP_SUB, 3'd2, 3'd0, 3'd1, 4'd0);
    driveCdb(2'd2, 16'd7);
    tick(); idle();
    checkOffer("t4.bypass", 2'd3, OP_SUB, 16'd7, 16'd1);
    checkOutput("t4.stall", 32'(stall), 32'd0);
    restart();

    $display("[TB] store, invalid opcode and load");
    fu_ready = 1'b1;
    applyStimulus(OP_SD, 3'd1, 3'd1, 3'd0, 4'd1);
    tick(); idle();
    checkOffer("t5.sd", 2'd1, OP_SD, 16'd1, 16'd1);
    checkOutput("t5.sd.imm", 32'(fu_imm), 32'd1);
    tick();
    driveCdb(2'd1, 16'hBEEF);
    tick(); idle();
    applyStimulus(3'b100, 3'd1, 3'd2, 3'd3, 4'd5);
    tick(); idle();
    checkOutput("t5.inv.fu_valid", 32'(fu_valid), 32'd0);
    checkOutput("t5.inv.stall", 32'(stall), 32'd0);
    applyStimulus(OP_ADD, 3'd0, 3'd1, 3'd1, 4'd0);
    tick(); idle();
    checkOffer("t5.after_sd", 2'd1, OP_ADD, 16'd1, 16'd1);
    tick();
    applyStimulus(OP_LD, 3'd5, 3'd2, 3'd0, 4'd9);
    tick(); idle();
    checkOutput("t5.ld.valid", 32'(fu_valid), 32'd1);
    checkOutput("t5.ld.tag", 32'(fu_tag), 32'd2);
    checkOutput("t5.ld.op", 32'(fu_op), 32'(OP_LD));
    checkOutput("t5.ld.vj", 32'(fu_vj), 32'd2);
    checkOutput("t5.ld.imm", 32'(fu_imm), 32'd9);
    tick();
    fu_ready = 1'b0;

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(OP_ADD, 3'd1, 3'd2, 3'd2, 4'd0);
    tick(); idle();
    checkOutput("t6.full.stall", 32'(stall), 32'd1);
    checkOffer("t6.full.offer", 2'd3, OP_ADD, 16'd2, 16'd2);
    #1 reset = 1'b0;
    #1;
    checkOutput("t6.rst.stall", 32'(stall), 32'd0);
    checkOutput("t6.rst.fu_valid", 32'(fu_valid), 32'd0);
    checkOutput("t6.rst.fu_tag", 32'(fu_tag), 32'd0);
    checkOutput("t6.rst.fu_vj", 32'(fu_vj), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    driveCdb(2'd1, 16'h0055);
    tick(); idle();
    checkOutput("t6.stale.stall", 32'(stall), 32'd0);
    checkOutput("t6.stale.fu_valid", 32'(fu_valid), 32'd0);
    fu_ready = 1'b1;
    applyStimulus(OP_ADD, 3'd3, 3'd0, 3'd1, 4'd0);
    tick(); idle();
    checkOffer("t6.regs_reset", 2'd1, OP_ADD, 16'd0, 16'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
